// File: rtl/iob_cdc_handshake_tx_if.sv
// ----------------------------------------------------------------------------
// iob_cdc_handshake_tx_if
//  Signal bundle for the source side of a two-phase (toggle) req/ack CDC
//  handshake.
//  Modports:
//   master - the transmitter block: takes data_i/valid_i/cdc_ack_i and drives
//            ready_o/busy_o/cdc_data_o/cdc_req_o (and timeout_o).
//   slave  - the environment: the local producer plus the remote end.
//  Signals:
//   data_i      DATA_W  word to send
//   valid_i     1       data_i valid
//   ready_o     1       block can accept
//   busy_o      1       transfer in flight
//   cdc_data_o  DATA_W  held word, stable while busy_o=1
//   cdc_req_o   1       request toggle
//   cdc_ack_i   1       ack toggle from the remote domain (asynchronous)
//   timeout_o   1       sticky timeout flag; present only when
//                       IOB_CDC_HANDSHAKE_TX_TIMEOUT_EN is defined
// ----------------------------------------------------------------------------
interface iob_cdc_handshake_tx_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic              busy_o;
    logic [DATA_W-1:0] cdc_data_o;
    logic              cdc_req_o;
    logic              cdc_ack_i;
`ifdef IOB_CDC_HANDSHAKE_TX_TIMEOUT_EN
    logic              timeout_o;

    modport master (
        input  data_i, valid_i, cdc_ack_i,
        output ready_o, busy_o, cdc_data_o, cdc_req_o, timeout_o
    );
    modport slave (
        output data_i, valid_i, cdc_ack_i,
        input  ready_o, busy_o, cdc_data_o, cdc_req_o, timeout_o
    );
`else
    modport master (
        input  data_i, valid_i, cdc_ack_i,
        output ready_o, busy_o, cdc_data_o, cdc_req_o
    );
    modport slave (
        output data_i, valid_i, cdc_ack_i,
        input  ready_o, busy_o, cdc_data_o, cdc_req_o
    );
`endif
endinterface

// File: rtl/iob_cdc_handshake_tx.sv
// ----------------------------------------------------------------------------
// iob_cdc_handshake_tx
//  Source-side end of a two-phase (toggle) req/ack clock-domain crossing.
//  A word accepted on the valid/ready port is held on cdc_data_o while
//  cdc_req_o toggles; the block then waits until the synchronised ack toggle
//  matches the request before accepting the next word. One word in flight.
//
//  Ports:
//   clk_i   in  clock
//   rst_i   in  synchronous active-high reset
//   bus     iob_cdc_handshake_tx_if.master (data_i, valid_i, ready_o, busy_o,
//           cdc_data_o, cdc_req_o, cdc_ack_i, optional timeout_o)
//
//  Parameters:
//   DATA_W       width of the transferred word
//   RST_VAL      reset value of cdc_data_o
//   SYNC_STAGES  ack synchroniser depth, 2..4 (values outside are clamped)
//   TIMEOUT_W    timeout counter width (used only with the timeout feature)
//
//  Build option:
//   IOB_CDC_HANDSHAKE_TX_TIMEOUT_EN - adds a wait counter and a sticky
//   timeout_o flag that rises once the counter reaches all-ones in WAIT_ACK.
//   The FSM never aborts on timeout: dropping a transfer would leave req and
//   ack with mismatched toggle parity.
// ----------------------------------------------------------------------------
module iob_cdc_handshake_tx #(
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  RST_VAL     = '0,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 TIMEOUT_W   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    iob_cdc_handshake_tx_if.master        bus
);

    // Keep the synchroniser within its legal depth.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 :
                            ((SYNC_STAGES > 4) ? 4 : SYNC_STAGES);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic              ready_reg, ready_next;
    logic              busy_reg,  busy_next;
    logic              req_reg,   req_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    logic [SYNC_N-1:0] ack_sync_reg;
    logic              ack_sync;
    logic              accept;

    assign ack_sync = ack_sync_reg[SYNC_N-1];
    // ready_reg is only ever high in IDLE, so this alone qualifies acceptance.
    assign accept   = bus.valid_i && ready_reg;

    // Ack synchroniser: cdc_ack_i is asynchronous to clk_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_sync_reg <= '0;
        end else begin
            ack_sync_reg <= {ack_sync_reg[SYNC_N-2:0], bus.cdc_ack_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            req_reg   <= 1'b0;
            data_reg  <= RST_VAL;
        end else begin
            state_reg <= state_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            req_reg   <= req_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready_next = ready_reg;
        busy_next  = busy_reg;
        req_next   = req_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                // Ack activity in IDLE is ignored; parity is re-checked
                // after the next request toggle.
                ready_next = 1'b1;
                busy_next  = 1'b0;
                if (accept) begin
                    state_next = WAIT_ACK;
                    data_next  = bus.data_i;
                    req_next   = ~req_reg;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            WAIT_ACK: begin
                // Data and req are frozen here; only completion is detected.
                if (ack_sync == req_reg) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready_o    = ready_reg;
    assign bus.busy_o     = busy_reg;
    assign bus.cdc_req_o  = req_reg;
    assign bus.cdc_data_o = data_reg;

`ifdef IOB_CDC_HANDSHAKE_TX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_reg, to_cnt_next, to_cnt_inc;
    logic                 timeout_reg, timeout_next;

    assign to_cnt_inc = to_cnt_reg + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            to_cnt_reg  <= to_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    // Counter saturates at all-ones so the flag is raised exactly once per
    // stalled transfer; the flag itself is sticky until reset.
    always_comb begin
        to_cnt_next  = to_cnt_reg;
        timeout_next = timeout_reg;
        if (accept) begin
            to_cnt_next = '0;
        end else if (state_reg == WAIT_ACK && to_cnt_reg != {TIMEOUT_W{1'b1}}) begin
            to_cnt_next = to_cnt_inc;
            if (to_cnt_inc == {TIMEOUT_W{1'b1}}) begin
                timeout_next = 1'b1;
            end
        end
    end

    assign bus.timeout_o = timeout_reg;
`else
    // TIMEOUT_W only sizes the timeout counter, which is not built here.
    logic unused_timeout_w;
    assign unused_timeout_w = (TIMEOUT_W != 0);
`endif

endmodule

// File: tb/tb_iob_cdc_handshake_tx.sv
// ----------------------------------------------------------------------------
// tb_iob_cdc_handshake_tx
//  Directed bench for iob_cdc_handshake_tx. A remote-end model on the falling
//  edge echoes cdc_req_o onto cdc_ack_i after remote_delay cycles and records
//  the word it sampled from cdc_data_o.
// ----------------------------------------------------------------------------
module tb_iob_cdc_handshake_tx;

    localparam int          DATA_W  = 32;
    localparam logic [31:0] RST_VAL = 32'h1234_5678;
    localparam int          SYNC    = 2;
    localparam int          TW      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iob_cdc_handshake_tx_if #(.DATA_W(DATA_W)) bus ();

    iob_cdc_handshake_tx #(
        .DATA_W      (DATA_W),
        .RST_VAL     (RST_VAL),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_W   (TW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;

    // Remote end model.
    bit          remote_en    = 1'b0;
    int          remote_delay = 4;
    int          remote_cnt   = 0;
    logic [31:0] cap_q[$];

    always @(negedge clk) begin
        if (rst) begin
            bus.cdc_ack_i = 1'b0;
            remote_cnt    = 0;
        end else if (remote_en && bus.cdc_req_o !== bus.cdc_ack_i) begin
            remote_cnt++;
            if (remote_cnt >= remote_delay) begin
                cap_q.push_back(bus.cdc_data_o);
                bus.cdc_ack_i = bus.cdc_req_o;
                remote_cnt    = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int c = 0;
        while (bus.ready_o !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
        check({tag, "_done"}, bus.ready_o, 1);
    endtask

    function automatic logic [31:0] cap_at(input int i);
        if (i < cap_q.size()) return cap_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = '0;

        // 1: reset, with valid_i asserted to show reset wins.
        bus.valid_i = 1'b1;
        bus.data_i  = 32'hFFFF_0000;
        repeat (3) tick();
        check("rst_ready", bus.ready_o, 0);
        check("rst_req",   bus.cdc_req_o, 0);
        check("rst_data",  bus.cdc_data_o, RST_VAL);
        check("rst_busy",  bus.busy_o, 0);
        bus.valid_i = 1'b0;
        rst = 1'b0;
        tick();
        check("rel_ready", bus.ready_o, 1);
        check("rel_data",  bus.cdc_data_o, RST_VAL);
        check("rel_req",   bus.cdc_req_o, 0);

        // 2: single transfer, remote echoes after 4 cycles.
        begin
            int n = 0, first_n = -1, ready_n = -1;
            bit unstable = 1'b0;
            remote_en = 1'b1;
            remote_delay = 4;
            bus.data_i  = 32'hA5A5_0001;
            bus.valid_i = 1'b1;
            tick();
            $display("xfer t2 word=0x%08h req=%0b", bus.cdc_data_o, bus.cdc_req_o);
            bus.valid_i = 1'b0;
            check("t2_req",   bus.cdc_req_o, 1);
            check("t2_data",  bus.cdc_data_o, 32'hA5A5_0001);
            check("t2_busy",  bus.busy_o, 1);
            check("t2_ready", bus.ready_o, 0);
            while (n < 50 && ready_n < 0) begin
                tick();
                n++;
                // The ack toggles on a falling edge, so this rising edge is
                // the first to sample it.
                if (first_n < 0 && bus.cdc_ack_i === bus.cdc_req_o) first_n = n;
                if (bus.ready_o === 1'b1) ready_n = n;
                else if (bus.cdc_data_o !== 32'hA5A5_0001 || bus.cdc_req_o !== 1'b1) unstable = 1'b1;
            end
            check("t2_done",    ready_n >= 0, 1);
            check("t2_latency", ready_n - first_n, SYNC);
            check("t2_stable",  unstable, 0);
            check("t2_busy_end", bus.busy_o, 0);
            check("t2_cap_n",   cap_q.size(), 1);
            check("t2_cap",     cap_at(0), 32'hA5A5_0001);
        end

        // 3: back-to-back, valid_i held high for words 0..7.
        begin
            int k = 0, toggles = 0;
            logic prev_req;
            logic [31:0] held = '0;
            bit unstable = 1'b0;
            cap_q.delete();
            remote_delay = 1;
            prev_req = bus.cdc_req_o;
            bus.data_i  = 0;
            bus.valid_i = 1'b1;
            for (int c = 0; c < 400 && (k < 8 || bus.ready_o !== 1'b1); c++) begin
                tick();
                if (bus.cdc_req_o !== prev_req) begin
                    toggles++;
                    prev_req = bus.cdc_req_o;
                    held = k;
                    if (bus.cdc_data_o !== held) unstable = 1'b1;
                    $display("xfer t3 word=0x%08h req=%0b", bus.cdc_data_o, bus.cdc_req_o);
                    k++;
                    if (k < 8) bus.data_i = k;
                    else bus.valid_i = 1'b0;
                end else if (bus.busy_o === 1'b1 && bus.cdc_data_o !== held) begin
                    unstable = 1'b1;
                end
            end
            bus.valid_i = 1'b0;
            check("t3_toggles", toggles, 8);
            check("t3_stable",  unstable, 0);
            check("t3_cap_n",   cap_q.size(), 8);
            for (int i = 0; i < 8; i++) check($sformatf("t3_cap%0d", i), cap_at(i), i);
        end

        // 4: valid_i/data_i activity while busy is ignored.
        begin
            logic req4;
            cap_q.delete();
            remote_delay = 8;
            bus.data_i  = 32'h0000_1111;
            bus.valid_i = 1'b1;
            tick();
            $display("xfer t4 word=0x%08h req=%0b", bus.cdc_data_o, bus.cdc_req_o);
            bus.valid_i = 1'b0;
            req4 = bus.cdc_req_o;
            check("t4_busy", bus.busy_o, 1);
            tick();
            bus.data_i  = 32'h0000_DEAD;
            bus.valid_i = 1'b1;
            tick();
            bus.valid_i = 1'b0;
            tick();
            check("t4_data_hold", bus.cdc_data_o, 32'h0000_1111);
            check("t4_req_hold",  bus.cdc_req_o, req4);
            check("t4_busy2",     bus.busy_o, 1);
            check("t4_ready",     bus.ready_o, 0);
            wait_ready("t4");
            check("t4_cap_n", cap_q.size(), 1);
            check("t4_cap",   cap_at(0), 32'h0000_1111);
            check("t4_req_end", bus.cdc_req_o, req4);
        end

        // 5: reset two cycles after acceptance, ack never returned.
        begin
            remote_en = 1'b0;
            cap_q.delete();
            bus.data_i  = 32'h0000_5555;
            bus.valid_i = 1'b1;
            tick();
            $display("xfer t5a word=0x%08h req=%0b", bus.cdc_data_o, bus.cdc_req_o);
            bus.valid_i = 1'b0;
            tick();
            tick();
            rst = 1'b1;
            tick();
            check("t5_req",   bus.cdc_req_o, 0);
            check("t5_ready", bus.ready_o, 0);
            check("t5_busy",  bus.busy_o, 0);
            check("t5_data",  bus.cdc_data_o, RST_VAL);
            rst = 1'b0;
            tick();
            check("t5_rel_ready", bus.ready_o, 1);
            remote_en = 1'b1;
            remote_delay = 3;
            bus.data_i  = 32'hCAFE_0005;
            bus.valid_i = 1'b1;
            tick();
            $display("xfer t5b word=0x%08h req=%0b", bus.cdc_data_o, bus.cdc_req_o);
            bus.valid_i = 1'b0;
            check("t5_req2",  bus.cdc_req_o, 1);
            check("t5_data2", bus.cdc_data_o, 32'hCAFE_0005);
            wait_ready("t5");
            check("t5_cap_n", cap_q.size(), 1);
            check("t5_cap",   cap_at(0), 32'hCAFE_0005);
        end

`ifdef IOB_CDC_HANDSHAKE_TX_TIMEOUT_EN
        // 6: remote never acks; flag after 15 WAIT_ACK cycles, late ack completes.
        begin
            check("t6_pre", bus.timeout_o, 0);
            remote_en = 1'b0;
            cap_q.delete();
            bus.data_i  = 32'h0000_6666;
            bus.valid_i = 1'b1;
            tick();
            $display("xfer t6 word=0x%08h req=%0b", bus.cdc_data_o, bus.cdc_req_o);
            bus.valid_i = 1'b0;
            repeat (14) tick();
            check("t6_at14", bus.timeout_o, 0);
            tick();
            check("t6_at15", bus.timeout_o, 1);
            repeat (5) tick();
            check("t6_sticky", bus.timeout_o, 1);
            check("t6_busy",   bus.busy_o, 1);
            remote_en = 1'b1;
            remote_delay = 1;
            wait_ready("t6");
            check("t6_after", bus.timeout_o, 1);
            check("t6_cap",   cap_at(0), 32'h0000_6666);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
